// File: rtl/rom_arb_pkg.sv
// +----------------------------------------------------------------------+
// | rom_arb_pkg : shared types and constants for the ROM access arbiter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package rom_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int ROM_LATENCY_DEFAULT = 13;

endpackage

`default_nettype wire

// File: rtl/rom_wait_counter.sv
// +----------------------------------------------------------------------+
// | rom_wait_counter : times the ROM wait window, expire on last cycle    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rom_wait_counter #(
  parameter int ROM_LATENCY = 13
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic load,
  output logic expire
);

  localparam int            CW   = $clog2(ROM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(ROM_LATENCY - 1);

  logic [CW-1:0] count_q, count_d;
  logic          run_q, run_d;

  assign expire = run_q && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    if (load) begin
      count_d = '0;
      run_d   = 1'b1;
    end else if (expire) begin
      run_d   = 1'b0;
    end else if (run_q) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_access_arbiter.sv
// +----------------------------------------------------------------------+
// | rom_access_arbiter : shares one slow ROM between fetch (F) and data   |
// | load (D) requesters. Define ROM_ARB_RR_EN for round-robin arbitration.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int ROM_LATENCY = ROM_LATENCY_DEFAULT
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          req_f,
  input  logic [AW-1:0] addr_f,
  input  logic          req_d,
  input  logic [AW-1:0] addr_d,
  input  logic [DW-1:0] rom_q,
  output logic [AW-1:0] rom_addr,
  output logic          ROMsel,
  output logic          gnt_f,
  output logic          gnt_d,
  output logic          done_f,
  output logic          done_d,
  output logic [DW-1:0] rd_data,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          pend_f_q, pend_f_d;
  logic          pend_d_q, pend_d_d;
  logic [AW-1:0] addr_f_q, addr_f_d;
  logic [AW-1:0] addr_d_q, addr_d_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          romsel_q, romsel_d;
  logic          gnt_f_q, gnt_f_d;
  logic          gnt_d_q, gnt_d_d;
  logic          done_f_q, done_f_d;
  logic          done_d_q, done_d_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          sel_q, sel_d;

  logic          load;
  logic          expire;
  logic          prio_f;
  logic          win_f;

  rom_wait_counter #(
    .ROM_LATENCY (ROM_LATENCY)
  ) u_wait (
    .Clk    (Clk),
    .Resetn (Resetn),
    .load   (load),
    .expire (expire)
  );

`ifdef ROM_ARB_RR_EN
  logic last_q, last_d;

  // F keeps priority unless it was the last port served.
  assign prio_f = (last_q == REQ_D);

  always_comb begin
    last_d = last_q;
    if (gnt_f_d)      last_d = REQ_F;
    else if (gnt_d_d) last_d = REQ_D;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) last_q <= REQ_D;
    else         last_q <= last_d;
  end
`else
  assign prio_f = 1'b1;
`endif

  assign win_f = pend_f_q && (!pend_d_q || prio_f);

  always_comb begin
    state_d    = state_q;
    pend_f_d   = pend_f_q;
    pend_d_d   = pend_d_q;
    addr_f_d   = addr_f_q;
    addr_d_d   = addr_d_q;
    rom_addr_d = rom_addr_q;
    romsel_d   = romsel_q;
    rd_data_d  = rd_data_q;
    sel_d      = sel_q;
    gnt_f_d    = 1'b0;
    gnt_d_d    = 1'b0;
    done_f_d   = 1'b0;
    done_d_d   = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_f_q || pend_d_q) begin
          load     = 1'b1;
          romsel_d = 1'b1;
          state_d  = ACCESS;
          if (win_f) begin
            rom_addr_d = addr_f_q;
            gnt_f_d    = 1'b1;
            pend_f_d   = 1'b0;
            sel_d      = REQ_F;
          end else begin
            rom_addr_d = addr_d_q;
            gnt_d_d    = 1'b1;
            pend_d_d   = 1'b0;
            sel_d      = REQ_D;
          end
        end
      end
      ACCESS: begin
        if (expire) begin
          rd_data_d = rom_q;
          romsel_d  = 1'b0;
          done_f_d  = (sel_q == REQ_F);
          done_d_d  = (sel_q == REQ_D);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request landing on its own grant edge re-arms the pending bit.
    if (req_f && (!pend_f_q || gnt_f_d)) begin
      pend_f_d = 1'b1;
      addr_f_d = addr_f;
    end
    if (req_d && (!pend_d_q || gnt_d_d)) begin
      pend_d_d = 1'b1;
      addr_d_d = addr_d;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      pend_f_q   <= 1'b0;
      pend_d_q   <= 1'b0;
      addr_f_q   <= '0;
      addr_d_q   <= '0;
      rom_addr_q <= '0;
      romsel_q   <= 1'b0;
      gnt_f_q    <= 1'b0;
      gnt_d_q    <= 1'b0;
      done_f_q   <= 1'b0;
      done_d_q   <= 1'b0;
      rd_data_q  <= '0;
      sel_q      <= REQ_F;
    end else begin
      state_q    <= state_d;
      pend_f_q   <= pend_f_d;
      pend_d_q   <= pend_d_d;
      addr_f_q   <= addr_f_d;
      addr_d_q   <= addr_d_d;
      rom_addr_q <= rom_addr_d;
      romsel_q   <= romsel_d;
      gnt_f_q    <= gnt_f_d;
      gnt_d_q    <= gnt_d_d;
      done_f_q   <= done_f_d;
      done_d_q   <= done_d_d;
      rd_data_q  <= rd_data_d;
      sel_q      <= sel_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign ROMsel   = romsel_q;
  assign gnt_f    = gnt_f_q;
  assign gnt_d    = gnt_d_q;
  assign done_f   = done_f_q;
  assign done_d   = done_d_q;
  assign rd_data  = rd_data_q;
  assign busy     = (state_q == ACCESS) || pend_f_q || pend_d_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_rom_access_arbiter : scoreboard bench for rom_access_arbiter       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rom_access_arbiter;

  localparam int LAT = 13;

  typedef struct {
    bit         port;
    logic [7:0] addr;
    int         gnt_cyc;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_f = 1'b0, req_d = 1'b0;
  logic [7:0]  addr_f = '0, addr_d = '0;
  logic [15:0] rom_q;
  logic [7:0]  rom_addr;
  logic        romsel, gnt_f, gnt_d, done_f, done_d, busy;
  logic [15:0] rd_data;

  logic        req_f1 = 1'b0;
  logic [7:0]  addr_f1 = '0;
  logic [15:0] rom_q1;
  logic [7:0]  rom_addr1;
  logic        romsel1, gnt_f1, gnt_d1, done_f1, done_d1, busy1;
  logic [15:0] rd_data1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hi_run = 0;
  exp_t gq[$];
  exp_t dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  assign rom_q  = rom_word(rom_addr);
  assign rom_q1 = rom_word(rom_addr1);

  rom_access_arbiter #(.AW(8), .DW(16), .ROM_LATENCY(LAT)) u_dut (
    .Clk(clk), .Resetn(rst_n),
    .req_f(req_f), .addr_f(addr_f), .req_d(req_d), .addr_d(addr_d),
    .rom_q(rom_q), .rom_addr(rom_addr), .ROMsel(romsel),
    .gnt_f(gnt_f), .gnt_d(gnt_d), .done_f(done_f), .done_d(done_d),
    .rd_data(rd_data), .busy(busy)
  );

  rom_access_arbiter #(.AW(8), .DW(16), .ROM_LATENCY(1)) u_dut1 (
    .Clk(clk), .Resetn(rst_n),
    .req_f(req_f1), .addr_f(addr_f1), .req_d(1'b0), .addr_d(8'h00),
    .rom_q(rom_q1), .rom_addr(rom_addr1), .ROMsel(romsel1),
    .gnt_f(gnt_f1), .gnt_d(gnt_d1), .done_f(done_f1), .done_d(done_d1),
    .rd_data(rd_data1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_acc(input bit port, input logic [7:0] a, input int g, input int d);
    exp_t e;
    e.port = port; e.addr = a; e.gnt_cyc = g; e.done_cyc = d;
    gq.push_back(e);
    dq.push_back(e);
  endtask

  // Drive request inputs so they are sampled at rising edge number e.
  task automatic issue_at(input int e, input bit rf, input logic [7:0] af,
                          input bit rd, input logic [7:0] ad);
    while (cyc < e - 1) @(negedge clk);
    req_f = rf; addr_f = af; req_d = rd; addr_d = ad;
    @(negedge clk);
    req_f = 1'b0; req_d = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((gq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(dq.size()), 0);
    @(negedge clk);
    chk("busy_after_drain", {31'b0, busy}, 0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a grant or done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hi_run = 0;
    end else begin
      if (gnt_f || gnt_d) begin
        if (gq.size() == 0) chk("gnt_unexpected", {30'b0, gnt_d, gnt_f}, 0);
        else begin
          e = gq.pop_front();
          chk("gnt_port", {30'b0, gnt_d, gnt_f}, e.port ? 32'd2 : 32'd1);
          chk("gnt_addr", {24'b0, rom_addr}, {24'b0, e.addr});
          chk("gnt_romsel", {31'b0, romsel}, 1);
          if (e.gnt_cyc >= 0) chk("gnt_cycle", cyc, e.gnt_cyc);
        end
      end
      if (done_f || done_d) begin
        if (dq.size() == 0) chk("done_unexpected", {30'b0, done_d, done_f}, 0);
        else begin
          e = dq.pop_front();
          chk("done_port", {30'b0, done_d, done_f}, e.port ? 32'd2 : 32'd1);
          chk("done_data", {16'b0, rd_data}, {16'b0, rom_word(e.addr)});
          if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
        end
      end
      if (romsel) hi_run++;
      else if (hi_run > 0) begin
        chk("romsel_width", hi_run, LAT);
        hi_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_romsel", {31'b0, romsel}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rom_addr", {24'b0, rom_addr}, 0);
    chk("rst_rd_data", {16'b0, rd_data}, 0);
    chk("rst_pulses", {28'b0, gnt_f, gnt_d, done_f, done_d}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch: grant one edge after request, done LAT edges later
    e0 = cyc + 2;
    expect_acc(0, 8'h12, e0 + 1, e0 + 14);
    issue_at(e0, 1, 8'h12, 0, 8'h00);
    chk("single_busy_pending", {31'b0, busy}, 1);
    wait_cyc(e0 + 14);
    chk("single_rd_data", {16'b0, rd_data}, 32'h0000D1ED);
    drain(100);

    // Simultaneous F and D: F first, one idle ROMsel cycle, then D
    e0 = cyc + 2;
    expect_acc(0, 8'h01, e0 + 1, e0 + 14);
    expect_acc(1, 8'h02, e0 + 15, e0 + 28);
    issue_at(e0, 1, 8'h01, 1, 8'h02);
    wait_cyc(e0 + 14);
    chk("gap_low", {31'b0, romsel}, 0);
    @(negedge clk);
    chk("gap_high_again", {31'b0, romsel}, 1);
    drain(100);

    // Tie while F is in flight: arbitration policy decides the order
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    e0 = cyc + 2;
`ifdef ROM_ARB_RR_EN
    expect_acc(0, 8'h10, e0 + 1, e0 + 14);
    expect_acc(1, 8'h20, e0 + 15, e0 + 28);
    expect_acc(0, 8'h11, e0 + 29, e0 + 42);
`else
    expect_acc(0, 8'h10, e0 + 1, e0 + 14);
    expect_acc(0, 8'h11, e0 + 15, e0 + 28);
    expect_acc(1, 8'h20, e0 + 29, e0 + 42);
`endif
    issue_at(e0, 1, 8'h10, 1, 8'h20);
    issue_at(e0 + 5, 1, 8'h11, 0, 8'h00);
    drain(150);

    // Three simultaneous F+D pairs: F,D,F,D,F,D
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    e0 = cyc + 2;
    expect_acc(0, 8'hA1, e0 + 1,  e0 + 14);
    expect_acc(1, 8'hB1, e0 + 15, e0 + 28);
    expect_acc(0, 8'hA2, e0 + 29, e0 + 42);
    expect_acc(1, 8'hB2, e0 + 43, e0 + 56);
    expect_acc(0, 8'hA3, e0 + 57, e0 + 70);
    expect_acc(1, 8'hB3, e0 + 71, e0 + 84);
    issue_at(e0,      1, 8'hA1, 1, 8'hB1);
    issue_at(e0 + 15, 1, 8'hA2, 1, 8'hB2);
    issue_at(e0 + 43, 1, 8'hA3, 1, 8'hB3);
    drain(200);

    // Duplicate D ignored while pending; D on its own grant edge re-queues
    e0 = cyc + 2;
    expect_acc(0, 8'h50, e0 + 1,  e0 + 14);
    expect_acc(1, 8'h30, e0 + 15, e0 + 28);
    expect_acc(1, 8'h41, e0 + 29, e0 + 42);
    issue_at(e0,      1, 8'h50, 0, 8'h00);
    issue_at(e0 + 2,  0, 8'h00, 1, 8'h30);
    issue_at(e0 + 4,  0, 8'h00, 1, 8'h40);
    issue_at(e0 + 15, 0, 8'h00, 1, 8'h41);
    drain(150);

    // Asynchronous reset in the middle of an access
    e0 = cyc + 2;
    gq.push_back('{port: 1'b0, addr: 8'h22, gnt_cyc: e0 + 1, done_cyc: -1});
    issue_at(e0,     1, 8'h22, 0, 8'h00);
    issue_at(e0 + 2, 0, 8'h00, 1, 8'h23);
    wait_cyc(e0 + 8);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_romsel", {31'b0, romsel}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_rom_addr", {24'b0, rom_addr}, 0);
    chk("abort_rd_data", {16'b0, rd_data}, 0);
    chk("abort_gq_consumed", 32'(gq.size()), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_pending", {31'b0, busy}, 0);
    e0 = cyc + 2;
    expect_acc(0, 8'h33, e0 + 1, e0 + 14);
    issue_at(e0, 1, 8'h33, 0, 8'h00);
    drain(100);

    // ROM_LATENCY = 1 instance
    @(negedge clk);
    req_f1 = 1'b1; addr_f1 = 8'h5A;
    @(negedge clk);
    req_f1 = 1'b0;
    chk("l1_pending_busy", {31'b0, busy1}, 1);
    @(negedge clk);
    chk("l1_gnt", {31'b0, gnt_f1}, 1);
    chk("l1_romsel_on", {31'b0, romsel1}, 1);
    chk("l1_rom_addr", {24'b0, rom_addr1}, 32'h5A);
    @(negedge clk);
    chk("l1_done", {30'b0, done_d1, done_f1}, 1);
    chk("l1_romsel_off", {31'b0, romsel1}, 0);
    chk("l1_rd_data", {16'b0, rd_data1}, {16'b0, rom_word(8'h5A)});
    @(negedge clk);
    chk("l1_idle", {29'b0, busy1, gnt_d1, done_f1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single slow instruction/data ROM between two requesters: instruction fetch (port F) and data load (port D).
- Captures single-cycle request pulses and arbitrates between pending requests.
- Drives the ROM address and ROMsel for a fixed wait window, then returns the captured word with a one-cycle done pulse.
- Sits between the control unit/fetch stage and the ROM.

Parameters:
- AW, 8, ROM address width.
- DW, 16, ROM data width.
- ROM_LATENCY, 13, cycles ROMsel is held high per access; legal range 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- req_f  in  1  fetch request pulse, one cycle.
- addr_f  in  AW  fetch address; sampled when req_f=1.
- req_d  in  1  data-load request pulse, one cycle.
- addr_d  in  AW  data address; sampled when req_d=1.
- rom_q  in  DW  ROM read data.
- rom_addr  out  AW  registered ROM address.
- ROMsel  out  1  ROM select, registered.
- gnt_f  out  1  one-cycle pulse: fetch access started.
- gnt_d  out  1  one-cycle pulse: data access started.
- done_f  out  1  one-cycle pulse: rd_data valid for fetch.
- done_d  out  1  one-cycle pulse: rd_data valid for data.
- rd_data  out  DW  last captured ROM word; held until the next capture.
- busy  out  1  high when in ACCESS or any request is pending.

Behaviour:
- Reset (async, Resetn=0): all outputs 0; rom_addr=0, rd_data=0; pending bits, stored addresses and counter cleared; state IDLE. Applies immediately mid-access; no done is produced for the aborted access.
- Pending capture:
  - A req_x pulse at edge E0 sets pend_x and stores addr_x.
  - req_x while pend_x is already set: ignored, first address kept.
  - req_x in the same cycle its grant occurs: re-sets pend_x with the new address (set wins over clear).
- States: IDLE, ACCESS.
- IDLE:
  - If either pend bit is set at an edge: load rom_addr from the winner's stored address, ROMsel<=1, count<=0, pulse gnt_winner, clear pend_winner, go to ACCESS.
  - Fastest path: request at E0, grant/ROMsel at E1.
- ACCESS:
  - count increments each edge.
  - At the edge where count==ROM_LATENCY-1: rd_data<=rom_q, ROMsel<=0, pulse done for the granted port, go to IDLE.
  - ROMsel therefore stays high exactly ROM_LATENCY cycles.
  - Total latency from request edge to done edge = 1+ROM_LATENCY with no contention.
- Back-to-back: a pending request is granted on the edge after done, so ROMsel is low for exactly one cycle between accesses.
- Arbitration without the feature: fixed priority, F beats D.
- New requests arriving during ACCESS only set pending; they never disturb the current access.
- Counter width is $clog2(ROM_LATENCY+1). With ROM_LATENCY=1, ACCESS lasts one cycle.
- done_f/done_d are never both high; gnt and done of different accesses never overlap.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-granted register (reset value D, so F wins the first tie) gives priority to the port not granted last when both are pending. Guarantees D waits at most one F access.
- Undefined: fixed F-over-D priority; no last-granted register.

Decomposition:
- Package rom_arb_pkg: state enum {IDLE, ACCESS}, requester ID constants REQ_F=0 / REQ_D=1, ROM_LATENCY default constant.
- Sub-module rom_wait_counter:
  - Inputs: load, Clk, Resetn.
  - Output: expire, a pulse at count==ROM_LATENCY-1.
  - Parameter: ROM_LATENCY.
  - The arbiter FSM uses it instead of an inline counter.

Test Plan:
- Reset then single req_f with addr_f=0x12 at cycle 5 -> gnt_f at cycle 6; ROMsel high cycles 6–18 with rom_addr=0x12; done_f at cycle 19; rd_data=rom_q(0x12).
- req_f and req_d same cycle (addr 0x01/0x02), fixed priority -> F served first; D granted the cycle after done_f; ROMsel low exactly one cycle between accesses.
- With ROM_ARB_RR_EN: three consecutive simultaneous F+D pairs -> grant order F,D,F,D,F,D.
- Second req_d (addr 0x40) while pend_d is set with 0x30 -> only one D access, to 0x30. req_d coincident with gnt_d -> a second access is queued.
- Resetn low at cycle 8 of an access -> ROMsel/busy drop asynchronously, no done pulse, pending cleared. After release, a new req_f completes normally.
- ROM_LATENCY=1 -> ROMsel high for one cycle; done the following edge; rd_data correct.
